// File: rtl/ram_controller_if.sv
// ram_controller_if: request/response handshake bundle for ram_controller.
//   req_valid/req_ready  request handshake
//   req_op               00 READ, 01 WRITE, 10 RMW, 11 reserved
//   req_address          target word
//   req_wdata            write data (WRITE, RMW)
//   req_mask             RMW bit select, 1 = take bit from req_wdata
//   rsp_valid/rsp_ready  response handshake
//   rsp_data             READ/RMW: pre-write word; WRITE: req_wdata; reserved: 0
//   rsp_error            reserved op, or parity failure when parity is built in
// Modports: master = requester, slave = controller.
interface ram_controller_if #(
  parameter int ADDRESS_BITS = 1,
  parameter int DATA_BITS    = 1
);
  logic                    req_valid;
  logic                    req_ready;
  logic [1:0]              req_op;
  logic [ADDRESS_BITS-1:0] req_address;
  logic [DATA_BITS-1:0]    req_wdata;
  logic [DATA_BITS-1:0]    req_mask;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DATA_BITS-1:0]    rsp_data;
  logic                    rsp_error;

  modport master (
    output req_valid, req_op, req_address, req_wdata, req_mask, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_error
  );

  modport slave (
    input  req_valid, req_op, req_address, req_wdata, req_mask, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_error
  );
endinterface

// File: rtl/ram_controller.sv
// ram_controller: request/response front end for a zero-delay single-channel RAM.
// Sole driver of the RAM address, write strobe and shared data bus. Handles one
// outstanding READ, WRITE or masked read-modify-write at a time.
// Ports:
//   clock        posedge clock
//   reset        synchronous, active-high
//   host         ram_controller_if.slave request/response bundle
//   ram_write    RAM write strobe (decode of state)
//   ram_address  RAM word address
//   ram_data     RAM data bus, driven only while ram_write=1
// Build option: define RAM_CTRL_PARITY_EN to widen the RAM word by one even-parity
// bit (bit DATA_BITS), written on every store and checked on every read.
module ram_controller #(
  parameter int ADDRESS_BITS = 1,
  parameter int DATA_BITS    = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  ram_controller_if.slave         host,
  output logic                    ram_write,
  output logic [ADDRESS_BITS-1:0] ram_address,
`ifdef RAM_CTRL_PARITY_EN
  inout  wire  [DATA_BITS:0]      ram_data
`else
  inout  wire  [DATA_BITS-1:0]    ram_data
`endif
);

`ifdef RAM_CTRL_PARITY_EN
  localparam int RAM_BITS = DATA_BITS + 1;
`else
  localparam int RAM_BITS = DATA_BITS;
`endif

  typedef enum logic [1:0] {IDLE, ACCESS, WRITEBACK, RESP} state_t;
  typedef enum logic [1:0] {OP_READ = 2'b00, OP_WRITE = 2'b01, OP_RMW = 2'b10, OP_RSVD = 2'b11} op_t;

  state_t                  state, state_next;
  op_t                     op;
  logic [ADDRESS_BITS-1:0] addr_q;
  logic [DATA_BITS-1:0]    wdata_q;
  logic [DATA_BITS-1:0]    mask_q;
  logic [DATA_BITS-1:0]    rsp_data_q;
  logic                    rsp_error_q;
  logic [DATA_BITS-1:0]    wr_data;
  logic [RAM_BITS-1:0]     wr_word;
  logic                    rd_error;
  logic                    req_ready;
  logic                    rsp_valid;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    ram_write  = 1'b0;
    wr_data    = wdata_q;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (host.req_valid)
          state_next = (op_t'(host.req_op) == OP_RSVD) ? RESP : ACCESS;
      end
      ACCESS: begin
        ram_write  = (op == OP_WRITE);
        state_next = (op == OP_RMW) ? WRITEBACK : RESP;
      end
      WRITEBACK: begin
        // rsp_data_q holds the pre-write word captured during ACCESS
        ram_write  = 1'b1;
        wr_data    = (rsp_data_q & ~mask_q) | (wdata_q & mask_q);
        state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (host.rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef RAM_CTRL_PARITY_EN
  // Even parity: the whole stored word XORs to zero when intact.
  assign wr_word  = {^wr_data, wr_data};
  assign rd_error = ^ram_data;
`else
  assign wr_word  = wr_data;
  assign rd_error = 1'b0;
`endif

  assign ram_data = ram_write ? wr_word : 'z;

  always_ff @(posedge clock) begin
    if (reset) begin
      op          <= OP_READ;
      addr_q      <= '0;
      wdata_q     <= '0;
      mask_q      <= '0;
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (host.req_valid) begin
            op      <= op_t'(host.req_op);
            addr_q  <= host.req_address;
            wdata_q <= host.req_wdata;
            mask_q  <= host.req_mask;
            if (op_t'(host.req_op) == OP_RSVD) begin
              rsp_data_q  <= '0;
              rsp_error_q <= 1'b1;
            end else begin
              rsp_error_q <= 1'b0;
            end
          end
        end
        ACCESS: begin
          if (op == OP_WRITE) begin
            rsp_data_q <= wdata_q;
          end else begin
            rsp_data_q  <= ram_data[DATA_BITS-1:0];
            rsp_error_q <= rd_error;
          end
        end
        default: ;
      endcase
    end
  end

  assign ram_address    = addr_q;
  assign host.req_ready = req_ready;
  assign host.rsp_valid = rsp_valid;
  assign host.rsp_data  = rsp_data_q;
  assign host.rsp_error = rsp_error_q;

endmodule

// File: tb/tb_ram_controller.sv
// tb_ram_controller: self-checking bench for ram_controller (ADDRESS_BITS=4,
// DATA_BITS=8) with a behavioural zero-delay RAM and a word-level reference model.
module tb_ram_controller;
  localparam int AB = 4;
  localparam int DB = 8;
`ifdef RAM_CTRL_PARITY_EN
  localparam int RB = DB + 1;
`else
  localparam int RB = DB;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ram_controller_if #(.ADDRESS_BITS(AB), .DATA_BITS(DB)) host ();

  logic          ram_write;
  logic [AB-1:0] ram_address;
  wire  [RB-1:0] ram_data;

  ram_controller #(.ADDRESS_BITS(AB), .DATA_BITS(DB)) dut (
    .clock       (clock),
    .reset       (reset),
    .host        (host),
    .ram_write   (ram_write),
    .ram_address (ram_address),
    .ram_data    (ram_data)
  );

  // Zero-delay RAM: combinational read, write sampled on the clock edge.
  logic [RB-1:0] mem [16];
  assign ram_data = ram_write ? {RB{1'bz}} : mem[ram_address];
  always @(posedge clock) if (ram_write) mem[ram_address] <= ram_data;

  int unsigned wr_cnt = 0;
  always @(posedge clock) if (ram_write) wr_cnt <= wr_cnt + 1;

  // Reference model: word contents and whether a word has bad stored parity.
  logic [DB-1:0] ref_mem [16];
  bit            ref_bad [16];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called and returns at a negedge. hold keeps req_valid high after acceptance.
  task automatic transact(input logic [1:0] op, input logic [3:0] a, input logic [7:0] wd,
                          input logic [7:0] mk, input int stall, input bit hold);
    logic [7:0]  exp_d;
    logic        exp_e;
    int          exp_lat;
    int          exp_wr;
    int          n;
    int          lat;
    int unsigned wr0;
    logic [7:0]  d0;
    exp_e = 1'b0;
    case (op)
      2'd0: begin exp_d = ref_mem[a]; exp_e = ref_bad[a]; exp_lat = 2; exp_wr = 0; end
      2'd1: begin exp_d = wd; ref_mem[a] = wd; ref_bad[a] = 0; exp_lat = 2; exp_wr = 1; end
      2'd2: begin
        exp_d = ref_mem[a]; exp_e = ref_bad[a];
        ref_mem[a] = (ref_mem[a] & ~mk) | (wd & mk); ref_bad[a] = 0;
        exp_lat = 3; exp_wr = 1;
      end
      default: begin exp_d = '0; exp_e = 1'b1; exp_lat = 1; exp_wr = 0; end
    endcase
    host.req_op = op; host.req_address = a; host.req_wdata = wd; host.req_mask = mk;
    host.req_valid = 1'b1;
    n = 0;
    while (host.req_ready !== 1'b1 && n < 50) begin @(negedge clock); n++; end
    if (n >= 50) begin
      check("accept_timeout", 32'd0, 32'd1);
      host.req_valid = 1'b0;
      return;
    end
    wr0 = wr_cnt;
    @(posedge clock);
    @(negedge clock);
    if (!hold) host.req_valid = 1'b0;
    lat = 1;
    while (host.rsp_valid !== 1'b1 && lat < 20) begin @(negedge clock); lat++; end
    check("latency", lat, exp_lat);
    check("rsp_data", host.rsp_data, exp_d);
    check("rsp_error", host.rsp_error, exp_e);
    d0 = host.rsp_data;
    for (int i = 0; i < stall; i++) begin
      check("busy_ready", host.req_ready, 1'b0);
      @(negedge clock);
      check("stall_valid", host.rsp_valid, 1'b1);
      check("stall_data", host.rsp_data, d0);
    end
    host.rsp_ready = 1'b1;
    @(negedge clock);
    host.rsp_ready = 1'b0;
    check("rsp_drop", host.rsp_valid, 1'b0);
    check("idle_ready", host.req_ready, 1'b1);
    check("ram_writes", wr_cnt - wr0, exp_wr);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned wr0;
    host.req_valid = 1'b0; host.req_op = '0; host.req_address = '0;
    host.req_wdata = '0; host.req_mask = '0; host.rsp_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin mem[i] = '0; ref_mem[i] = '0; ref_bad[i] = 0; end
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_req_ready", host.req_ready, 1'b1);
    check("rst_rsp_valid", host.rsp_valid, 1'b0);
    check("rst_rsp_data", host.rsp_data, 8'h00);
    check("rst_rsp_error", host.rsp_error, 1'b0);
    check("rst_ram_write", ram_write, 1'b0);
    check("rst_ram_address", ram_address, 4'h0);
    reset = 1'b0;
    @(negedge clock);

    // WRITE then READ, same address
    transact(2'd1, 4'd3, 8'hA5, 8'h00, 0, 0);
    transact(2'd0, 4'd3, 8'h00, 8'h00, 0, 0);
    // masked RMW
    transact(2'd1, 4'd7, 8'hF0, 8'h00, 0, 0);
    transact(2'd2, 4'd7, 8'h0F, 8'h3C, 0, 0);
    transact(2'd0, 4'd7, 8'h00, 8'h00, 0, 0);
    // response back-pressure with the next request already pending
    transact(2'd0, 4'd3, 8'h00, 8'h00, 5, 1);
    transact(2'd0, 4'd3, 8'h00, 8'h00, 0, 0);
    // reserved op
    transact(2'd3, 4'd2, 8'h77, 8'hFF, 1, 0);

    // reset held two cycles in the middle of an RMW
    transact(2'd1, 4'd9, 8'h5A, 8'h00, 0, 0);
    host.req_op = 2'd2; host.req_address = 4'd9; host.req_wdata = 8'hFF; host.req_mask = 8'hFF;
    host.req_valid = 1'b1;
    wr0 = wr_cnt;
    @(posedge clock);
    @(negedge clock);
    host.req_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("abort_req_ready", host.req_ready, 1'b1);
    check("abort_rsp_valid", host.rsp_valid, 1'b0);
    check("abort_ram_write", ram_write, 1'b0);
    check("abort_writes", wr_cnt - wr0, 32'd0);
    @(negedge clock);
    check("abort_no_rsp", host.rsp_valid, 1'b0);
    transact(2'd0, 4'd9, 8'h00, 8'h00, 0, 0);

`ifdef RAM_CTRL_PARITY_EN
    transact(2'd1, 4'd5, 8'h3B, 8'h00, 0, 0);
    mem[5][DB] = ~mem[5][DB];
    ref_bad[5] = 1;
    transact(2'd0, 4'd5, 8'h00, 8'h00, 0, 0);
    transact(2'd2, 4'd5, 8'hC4, 8'h0F, 0, 0);
    transact(2'd0, 4'd5, 8'h00, 8'h00, 0, 0);
`endif

    // randomized traffic against the reference model
    repeat (80) begin
      transact(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 8'($urandom),
               8'($urandom), int'($urandom_range(0, 3)), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
